inv_lift_row: RTL and testbench

- Streaming inverse 5/3 (reversible) lifting engine for one DWT row; the decode-side counterpart of the forward lift_step.
- Accepts interleaved subband coefficients s0,d0,s1,d1,… of signed W_IN width and reconstructs samples x0,x1,… as unsigned W_OUT pixels.
- Sits between the coefficient reader/dequantiser and the pixel writer.
- Handles symmetric boundary extension internally and processes rows back to back.

---
 rtl/inv_lift_pkg.sv | 19 +
 rtl/inv_lift_fifo2.sv | 64 ++++++
 rtl/inv_lift_row.sv | 173 +++++++++++++++++
 tb/tb_inv_lift_row.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/inv_lift_pkg.sv
// Shared types and defaults for the inverse 5/3 lifting row engine.
package inv_lift_pkg;

  localparam int unsigned DEF_W_IN      = 9;
  localparam int unsigned DEF_W_OUT     = 8;
  localparam int unsigned DEF_ROW_LEN   = 256;
  localparam int unsigned DEF_W_INT     = DEF_W_IN + 2;
  localparam int unsigned DEF_DC_OFFSET = 1 << (DEF_W_OUT - 1);
  localparam int unsigned DEF_PIX_MAX   = (1 << DEF_W_OUT) - 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;
  typedef enum logic {PAR_S = 1'b0, PAR_D = 1'b1} par_e;

  // DC level-shift offset for a given unsigned pixel width
  function automatic int unsigned dc_offset(input int unsigned w_out);
    return 32'd1 << (w_out - 1);
  endfunction

endpackage

// File: rtl/inv_lift_fifo2.sv
// Two-entry in-order queue: up to two pushes and one pop per cycle, head held in a register.
module inv_lift_fifo2 #(
  parameter int unsigned W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_push_n,
  input  logic [W-1:0] i_wdata0,
  input  logic [W-1:0] i_wdata1,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem0, r_mem1;
  logic [1:0]   r_cnt;
  logic         r_valid;
  logic [W-1:0] w_mem0_nxt, w_mem1_nxt;
  logic [1:0]   w_cnt_nxt;

  // Pop shifts the queue first, then pushes append behind whatever remains
  always_comb begin
    w_mem0_nxt = r_mem0;
    w_mem1_nxt = r_mem1;
    w_cnt_nxt  = r_cnt;
    if (i_pop && (r_cnt != 2'd0)) begin
      w_mem0_nxt = r_mem1;
      w_cnt_nxt  = r_cnt - 2'd1;
    end
    if (i_push_n != 2'd0) begin
      if (w_cnt_nxt == 2'd0) begin
        w_mem0_nxt = i_wdata0;
        w_cnt_nxt  = 2'd1;
      end else if (w_cnt_nxt == 2'd1) begin
        w_mem1_nxt = i_wdata0;
        w_cnt_nxt  = 2'd2;
      end
    end
    if ((i_push_n == 2'd2) && (w_cnt_nxt == 2'd1)) begin
      w_mem1_nxt = i_wdata1;
      w_cnt_nxt  = 2'd2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_mem0  <= w_mem0_nxt;
      r_mem1  <= w_mem1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
    end
  end

  assign o_head  = r_mem0;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/inv_lift_row.sv
// Streaming inverse 5/3 lifting for one DWT row with symmetric extension and pixel clamping.
// Optional: define INV_LIFT_DC_SHIFT_EN to add 2^(W_OUT-1) before the clamp.
module inv_lift_row
  import inv_lift_pkg::*;
#(
  parameter int unsigned W_IN    = DEF_W_IN,
  parameter int unsigned W_OUT   = DEF_W_OUT,
  parameter int unsigned ROW_LEN = DEF_ROW_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic signed [W_IN-1:0] coef_i,
  input  logic                   coef_valid_i,
  output logic                   coef_ready_o,
  output logic [W_OUT-1:0]       pix_o,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic                   pix_last_o,
  output logic                   sat_o,
  output logic                   busy_o
);

  localparam int unsigned W_INT = W_IN + 2;
  localparam int unsigned W_EXT = W_INT + 1;
  localparam int unsigned W_ENT = W_OUT + 1;
  localparam int unsigned N     = ROW_LEN / 2;
  localparam int unsigned W_IDX = (N > 1) ? $clog2(N) : 1;
`ifdef INV_LIFT_DC_SHIFT_EN
  localparam int unsigned DC    = dc_offset(W_OUT);
`else
  localparam int unsigned DC    = 0;
`endif
  localparam logic signed [W_EXT-1:0] DC_EXT  = W_EXT'(DC);
  localparam logic signed [W_EXT-1:0] MAX_EXT = W_EXT'((1 << W_OUT) - 1);

  // Returns {clamped_flag, pixel}
  function automatic logic [W_OUT:0] clamp_pix(input logic signed [W_INT-1:0] v);
    logic signed [W_EXT-1:0] t;
    t = W_EXT'(v) + DC_EXT;
    if (t < 0)            return {1'b1, {W_OUT{1'b0}}};
    else if (t > MAX_EXT) return {1'b1, {W_OUT{1'b1}}};
    else                  return {1'b0, t[W_OUT-1:0]};
  endfunction

  state_e                   r_state, w_state_nxt;
  par_e                     r_par, w_par_nxt;
  logic [W_IDX-1:0]         r_idx, w_idx_nxt;
  logic signed [W_INT-1:0]  r_s, w_s_nxt;
  logic signed [W_INT-1:0]  r_d_prev, w_d_prev_nxt;
  logic signed [W_INT-1:0]  r_xe_prev, w_xe_prev_nxt;
  logic                     r_sat, w_sat_nxt;
  logic                     r_ready, w_ready_nxt;
  logic                     r_busy, w_busy_nxt;

  logic signed [W_INT-1:0]  w_c, w_dm1, w_xe, w_xo, w_xo_last;
  logic [W_OUT:0]           w_clamp_xe, w_clamp_xo, w_clamp_last;
  logic                     w_accept, w_pop;
  logic [1:0]               w_push_n, w_fifo_cnt, w_cnt_nxt;
  logic [W_ENT-1:0]         w_wd0, w_wd1, w_head;
  logic                     w_fifo_valid;

  // Lifting datapath; d[-1] mirrors d[0] and xe[N] mirrors xe[N-1]
  assign w_c          = W_INT'(coef_i);
  assign w_dm1        = (r_idx == '0) ? w_c : r_d_prev;
  assign w_xe         = r_s - ((w_dm1 + w_c + W_INT'(2)) >>> 2);
  assign w_xo         = r_d_prev + ((r_xe_prev + w_xe) >>> 1);
  assign w_xo_last    = r_d_prev + ((r_xe_prev + r_xe_prev) >>> 1);
  assign w_clamp_xe   = clamp_pix(w_xe);
  assign w_clamp_xo   = clamp_pix(w_xo);
  assign w_clamp_last = clamp_pix(w_xo_last);

  assign w_accept = coef_valid_i & r_ready;
  assign w_pop    = w_fifo_valid & pix_ready_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_par_nxt     = r_par;
    w_idx_nxt     = r_idx;
    w_s_nxt       = r_s;
    w_d_prev_nxt  = r_d_prev;
    w_xe_prev_nxt = r_xe_prev;
    w_sat_nxt     = r_sat;
    w_push_n      = 2'd0;
    w_wd0         = '0;
    w_wd1         = '0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          if (r_par == PAR_S) begin
            w_s_nxt   = w_c;
            w_par_nxt = PAR_D;
            if (r_idx == '0) w_sat_nxt = 1'b0;
          end else begin
            w_d_prev_nxt  = w_c;
            w_xe_prev_nxt = w_xe;
            w_par_nxt     = PAR_S;
            if (r_idx == '0) begin
              w_push_n  = 2'd1;
              w_wd0     = {1'b0, w_clamp_xe[W_OUT-1:0]};
              w_sat_nxt = r_sat | w_clamp_xe[W_OUT];
            end else begin
              w_push_n  = 2'd2;
              w_wd0     = {1'b0, w_clamp_xo[W_OUT-1:0]};
              w_wd1     = {1'b0, w_clamp_xe[W_OUT-1:0]};
              w_sat_nxt = r_sat | w_clamp_xo[W_OUT] | w_clamp_xe[W_OUT];
            end
            if (r_idx == W_IDX'(N - 1)) w_state_nxt = FLUSH;
            else                        w_idx_nxt   = r_idx + W_IDX'(1);
          end
        end
      end
      FLUSH: begin
        if (w_fifo_cnt < 2'd2) begin
          w_push_n    = 2'd1;
          w_wd0       = {1'b1, w_clamp_last[W_OUT-1:0]};
          w_sat_nxt   = r_sat | w_clamp_last[W_OUT];
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end
      end
      default: ;
    endcase
    // Registered ready/busy are computed from the post-edge state
    w_cnt_nxt   = w_fifo_cnt - {1'b0, w_pop} + w_push_n;
    w_ready_nxt = (w_state_nxt == RUN) && ((w_par_nxt == PAR_S) || (w_cnt_nxt == 2'd0));
    w_busy_nxt  = (w_par_nxt == PAR_D) || (w_idx_nxt != '0) ||
                  (w_state_nxt == FLUSH) || (w_cnt_nxt != 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= RUN;
      r_par     <= PAR_S;
      r_idx     <= '0;
      r_s       <= '0;
      r_d_prev  <= '0;
      r_xe_prev <= '0;
      r_sat     <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_par     <= w_par_nxt;
      r_idx     <= w_idx_nxt;
      r_s       <= w_s_nxt;
      r_d_prev  <= w_d_prev_nxt;
      r_xe_prev <= w_xe_prev_nxt;
      r_sat     <= w_sat_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  inv_lift_fifo2 #(.W(W_ENT)) u_fifo (
    .i_clk    (clk_i),
    .i_rst_n  (rst_n_i),
    .i_push_n (w_push_n),
    .i_wdata0 (w_wd0),
    .i_wdata1 (w_wd1),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_valid  (w_fifo_valid),
    .o_cnt    (w_fifo_cnt)
  );

  assign coef_ready_o = r_ready;
  assign pix_o        = w_head[W_OUT-1:0];
  assign pix_last_o   = w_head[W_OUT];
  assign pix_valid_o  = w_fifo_valid;
  assign sat_o        = r_sat;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_inv_lift_row.sv
// Directed bench for inv_lift_row at ROW_LEN=4; expectations track INV_LIFT_DC_SHIFT_EN.
module tb_inv_lift_row;

  localparam int unsigned W_IN    = 9;
  localparam int unsigned W_OUT   = 8;
  localparam int unsigned ROW_LEN = 4;
`ifdef INV_LIFT_DC_SHIFT_EN
  localparam int SOFF = -128;
`else
  localparam int SOFF = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [W_IN-1:0] coef_i;
  logic                   coef_valid_i;
  logic                   coef_ready_o;
  logic [W_OUT-1:0]       pix_o;
  logic                   pix_valid_o;
  logic                   pix_ready_i;
  logic                   pix_last_o;
  logic                   sat_o;
  logic                   busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  inv_lift_row #(.W_IN(W_IN), .W_OUT(W_OUT), .ROW_LEN(ROW_LEN)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .coef_i       (coef_i),
    .coef_valid_i (coef_valid_i),
    .coef_ready_o (coef_ready_o),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_last_o   (pix_last_o),
    .sat_o        (sat_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " pix_o"},        int'(pix_o),        0);
    check_eq({tag, " pix_valid_o"},  int'(pix_valid_o),  0);
    check_eq({tag, " pix_last_o"},   int'(pix_last_o),   0);
    check_eq({tag, " coef_ready_o"}, int'(coef_ready_o), 0);
    check_eq({tag, " sat_o"},        int'(sat_o),        0);
    check_eq({tag, " busy_o"},       int'(busy_o),       0);
  endtask

  // Streams one row; pix_ready_i is held low for the first 'hold' cycles
  task automatic run_row(input string tag, input int c[4], input int e[4],
                         input int exp_sat, input int hold);
    int  ci = 0;
    int  k = 0;
    int  cyc = 0;
    bit  s0_seen = 1'b0;
    bit  s0_checked = 1'b0;
    while (((ci < 4) || (k < 4)) && (cyc < 100)) begin
      @(negedge clk);
      if (s0_seen && !s0_checked) begin
        check_eq({tag, " sat clear on s0"}, int'(sat_o), 0);
        s0_checked = 1'b1;
      end
      coef_valid_i = (ci < 4);
      coef_i       = '0;
      if (ci < 4) coef_i = W_IN'(c[ci]);
      pix_ready_i  = (cyc >= hold);
      if ((hold > 0) && (cyc == hold)) begin
        check_eq({tag, " held valid"},  int'(pix_valid_o),  1);
        check_eq({tag, " held pix"},    int'(pix_o),        e[0]);
        check_eq({tag, " d1 blocked"},  int'(coef_ready_o), 0);
        check_eq({tag, " coefs taken"}, ci,                 3);
      end
      if (pix_valid_o && pix_ready_i) begin
        if (k < 4) begin
          check_eq($sformatf("%s pix[%0d]", tag, k),  int'(pix_o),      e[k]);
          check_eq($sformatf("%s last[%0d]", tag, k), int'(pix_last_o), int'(k == 3));
        end else begin
          check_eq({tag, " extra pixel"}, k, 3);
        end
        k++;
      end
      if (coef_valid_i && coef_ready_o) begin
        if (ci == 0) s0_seen = 1'b1;
        ci++;
      end
      cyc++;
    end
    if (cyc >= 100) check_eq({tag, " timeout coefs*10+pixels"}, ci * 10 + k, 44);
    @(negedge clk);
    coef_valid_i = 1'b0;
    check_eq({tag, " sat_o"},  int'(sat_o),  exp_sat);
    check_eq({tag, " busy_o"}, int'(busy_o), 0);
  endtask

  int nom_c[4];
  int nom_e[4];
  int pos_c[4];
  int pos_e[4];
  int neg_c[4];
  int neg_e[4];

  initial begin
    int ci;
    int cyc;
    nom_c = '{120 + SOFF, 103, 211 + SOFF, 87};
    nom_e = '{68, 218, 163, 250};
    pos_c = '{255 + SOFF, 255, 255 + SOFF, 255};
    pos_e = '{127, 255, 127, 255};
    neg_c = '{-256, 0, 0, 0};
`ifdef INV_LIFT_DC_SHIFT_EN
    neg_e = '{0, 0, 128, 128};
`else
    neg_e = '{0, 0, 0, 0};
`endif

    rst_n        = 1'b0;
    coef_i       = '0;
    coef_valid_i = 1'b0;
    pix_ready_i  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_row("nominal",   nom_c, nom_e, 0, 0);
    run_row("pos_sat",   pos_c, pos_e, 1, 0);
    run_row("after_sat", nom_c, nom_e, 0, 0);
    run_row("neg_sat",   neg_c, neg_e, 1, 0);
    run_row("backpress", nom_c, nom_e, 0, 8);

    // Feed s0,d0,s1 then pull reset mid-row
    ci  = 0;
    cyc = 0;
    pix_ready_i = 1'b0;
    while ((ci < 3) && (cyc < 50)) begin
      @(negedge clk);
      coef_valid_i = 1'b1;
      coef_i       = W_IN'(nom_c[ci]);
      if (coef_ready_o) ci++;
      cyc++;
    end
    check_eq("midrow coefs accepted", ci, 3);
    @(negedge clk);
    coef_valid_i = 1'b0;
    check_eq("midrow busy before reset", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrow reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_row("post_reset", nom_c, nom_e, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
